// File: rtl/math_pipelined_sequencer_pkg.sv
// Shared definitions for sequencers that front the pipelined ALU.
// Holds the sequencer state encoding, the ALU flag bundle layout and the
// settle-window derivation used to size the wait between operand load and
// result capture.
package math_pipelined_sequencer_pkg;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_OUT    = 2'd2
    } seq_state_t;

    // Single-bit ALU results carried as one bundle.
    typedef struct packed {
        logic red_and;
        logic red_or;
        logic red_xor;
        logic eq;
        logic neq;
    } alu_flags_t;

    // ALU register stages between the operand register and a valid result.
    function automatic int unsigned settle_cycles(input int unsigned latency);
        return latency + 32'd1;
    endfunction

endpackage

// File: rtl/math_pipelined.sv
// Pipelined ALU: sum/difference (wrapping), reductions of I1 and I1-vs-I3
// compare, delayed by LATENCY register stages (LATENCY=0: combinational).
// Ports:
//   clk, rst_n          clock, async active-low reset of the stage registers
//   i1, i2, i3          operands (WIDTH bits)
//   o_sum, o_sub        I1+I2, I1-I2 mod 2^WIDTH
//   o_and/o_or/o_xor    reductions of I1
//   o_eq, o_neq         I1==I3, I1!=I3
module math_pipelined #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned LATENCY = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i3,
    output logic [WIDTH-1:0] o_sum,
    output logic [WIDTH-1:0] o_sub,
    output logic             o_and,
    output logic             o_or,
    output logic             o_xor,
    output logic             o_eq,
    output logic             o_neq
);

    localparam int unsigned RES_W = 2 * WIDTH + 5;

    logic [RES_W-1:0] res_c;
    logic [RES_W-1:0] res_out;

    // Raw results; carries out of the top bit are dropped.
    always_comb begin
        res_c = {WIDTH'(i1 + i2), WIDTH'(i1 - i2), &i1, |i1, ^i1, (i1 == i3), (i1 != i3)};
    end

    generate
        if (LATENCY == 0) begin : g_comb
            logic unused_c;
            assign unused_c = clk ^ rst_n;
            assign res_out  = res_c;
        end else begin : g_pipe
            logic [RES_W-1:0] pipe_q [LATENCY];
            logic [RES_W-1:0] pipe_d [LATENCY];

            // Shift the result bundle one stage per clock.
            always_comb begin
                pipe_d[0] = res_c;
                for (int unsigned i = 1; i < LATENCY; i++) begin
                    pipe_d[i] = pipe_q[i-1];
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pipe_q <= '{default: '0};
                end else begin
                    pipe_q <= pipe_d;
                end
            end

            assign res_out = pipe_q[LATENCY-1];
        end
    endgenerate

    assign {o_sum, o_sub, o_and, o_or, o_xor, o_eq, o_neq} = res_out;

endmodule

// File: rtl/math_pipelined_sequencer.sv
// Valid/ready front end for math_pipelined. Accepts an operand triple, holds
// it on the ALU for the settle window, captures all results and presents them
// until the consumer takes them.
// Optional feature macro: MATH_SEQUENCER_TAG_EN adds TAG_W, in_tag, out_tag.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_valid/in_ready          operand channel; in_i1, in_i2, in_i3 operands
//   out_valid/out_ready        result channel
//   out_sum, out_sub           I1+I2, I1-I2 mod 2^WIDTH
//   out_and/out_or/out_xor     reductions of I1
//   out_eq, out_neq            I1==I3, I1!=I3
//   busy                       high whenever not idle
module math_pipelined_sequencer
    import math_pipelined_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned LATENCY = 4
`ifdef MATH_SEQUENCER_TAG_EN
    ,
    parameter int unsigned TAG_W   = 4
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_i1,
    input  logic [WIDTH-1:0] in_i2,
    input  logic [WIDTH-1:0] in_i3,
`ifdef MATH_SEQUENCER_TAG_EN
    input  logic [TAG_W-1:0] in_tag,
    output logic [TAG_W-1:0] out_tag,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic [WIDTH-1:0] out_sub,
    output logic             out_and,
    output logic             out_or,
    output logic             out_xor,
    output logic             out_eq,
    output logic             out_neq,
    output logic             busy
);

    localparam int unsigned SETTLE = settle_cycles(LATENCY);
    localparam int unsigned CNT_W  = $clog2(SETTLE + 1);

    seq_state_t       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] op1_q, op1_d;
    logic [WIDTH-1:0] op2_q, op2_d;
    logic [WIDTH-1:0] op3_q, op3_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [WIDTH-1:0] sub_q, sub_d;
    alu_flags_t       flags_q, flags_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;
    logic             busy_q, busy_d;
`ifdef MATH_SEQUENCER_TAG_EN
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
`endif

    logic [WIDTH-1:0] alu_sum, alu_sub;
    alu_flags_t       alu_flags;

    // ALU sees only the operand registers, so its inputs never change mid-op.
    math_pipelined #(
        .WIDTH   (WIDTH),
        .LATENCY (LATENCY)
    ) u_alu (
        .clk   (clk),
        .rst_n (rst_n),
        .i1    (op1_q),
        .i2    (op2_q),
        .i3    (op3_q),
        .o_sum (alu_sum),
        .o_sub (alu_sub),
        .o_and (alu_flags.red_and),
        .o_or  (alu_flags.red_or),
        .o_xor (alu_flags.red_xor),
        .o_eq  (alu_flags.eq),
        .o_neq (alu_flags.neq)
    );

    // Next-state and register updates.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        op3_d       = op3_q;
        sum_d       = sum_q;
        sub_d       = sub_q;
        flags_d     = flags_q;
        out_valid_d = out_valid_q;
`ifdef MATH_SEQUENCER_TAG_EN
        tag_d       = tag_q;
        out_tag_d   = out_tag_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    op1_d   = in_i1;
                    op2_d   = in_i2;
                    op3_d   = in_i3;
                    count_d = CNT_W'(SETTLE);
                    state_d = ST_SETTLE;
`ifdef MATH_SEQUENCER_TAG_EN
                    tag_d   = in_tag;
`endif
                end
            end
            ST_SETTLE: begin
                // The extra count beyond LATENCY flushes any prior-op history.
                if (count_q != '0) begin
                    count_d = count_q - CNT_W'(1);
                end else begin
                    sum_d       = alu_sum;
                    sub_d       = alu_sub;
                    flags_d     = alu_flags;
                    out_valid_d = 1'b1;
                    state_d     = ST_OUT;
`ifdef MATH_SEQUENCER_TAG_EN
                    out_tag_d   = tag_q;
`endif
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status outputs are registered from the next state.
        in_ready_d = (state_d == ST_IDLE);
        busy_d     = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            op1_q       <= '0;
            op2_q       <= '0;
            op3_q       <= '0;
            sum_q       <= '0;
            sub_q       <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
`ifdef MATH_SEQUENCER_TAG_EN
            tag_q       <= '0;
            out_tag_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            op3_q       <= op3_d;
            sum_q       <= sum_d;
            sub_q       <= sub_d;
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
`ifdef MATH_SEQUENCER_TAG_EN
            tag_q       <= tag_d;
            out_tag_q   <= out_tag_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_sum   = sum_q;
    assign out_sub   = sub_q;
    assign out_and   = flags_q.red_and;
    assign out_or    = flags_q.red_or;
    assign out_xor   = flags_q.red_xor;
    assign out_eq    = flags_q.eq;
    assign out_neq   = flags_q.neq;
`ifdef MATH_SEQUENCER_TAG_EN
    assign out_tag   = out_tag_q;
`endif

endmodule

// File: tb/tb_math_pipelined_sequencer.sv
// Bench for math_pipelined_sequencer: a WIDTH=8/LATENCY=4 instance checked every
// cycle against a timestamp-based reference model, plus a WIDTH=5/LATENCY=0
// instance for the combinational-ALU corner.
module tb_math_pipelined_sequencer;

    localparam int unsigned W  = 8;
    localparam int unsigned L  = 4;
    localparam int unsigned W0 = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=8, LATENCY=4 instance
    logic         in_valid, in_ready, out_valid, out_ready, busy;
    logic [W-1:0] in_i1, in_i2, in_i3, out_sum, out_sub;
    logic         out_and, out_or, out_xor, out_eq, out_neq;

    // WIDTH=5, LATENCY=0 instance
    logic          d0_in_valid, d0_in_ready, d0_out_valid, d0_out_ready, d0_busy;
    logic [W0-1:0] d0_in_i1, d0_in_i2, d0_in_i3, d0_out_sum, d0_out_sub;
    logic          d0_out_and, d0_out_or, d0_out_xor, d0_out_eq, d0_out_neq;

    int vectors = 0;
    int miscompares = 0;

    math_pipelined_sequencer #(.WIDTH(W), .LATENCY(L)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_i1(in_i1), .in_i2(in_i2), .in_i3(in_i3),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_sub(out_sub),
        .out_and(out_and), .out_or(out_or), .out_xor(out_xor),
        .out_eq(out_eq), .out_neq(out_neq), .busy(busy)
    );

    math_pipelined_sequencer #(.WIDTH(W0), .LATENCY(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(d0_in_valid), .in_ready(d0_in_ready),
        .in_i1(d0_in_i1), .in_i2(d0_in_i2), .in_i3(d0_in_i3),
        .out_valid(d0_out_valid), .out_ready(d0_out_ready),
        .out_sum(d0_out_sum), .out_sub(d0_out_sub),
        .out_and(d0_out_and), .out_or(d0_out_or), .out_xor(d0_out_xor),
        .out_eq(d0_out_eq), .out_neq(d0_out_neq), .busy(d0_busy)
    );

    typedef struct packed {
        logic [7:0] sum;
        logic [7:0] sub;
        logic       a;
        logic       o;
        logic       x;
        logic       e;
        logic       n;
    } res8_t;

    // Reference results from plain integer arithmetic.
    function automatic res8_t ref8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        res8_t r;
        int s;
        int d;
        s = (int'(a) + int'(b)) % 256;
        d = (int'(a) - int'(b) + 256) % 256;
        r.sum = 8'(s);
        r.sub = 8'(d);
        r.a   = (a == 8'd255);
        r.o   = (a != 8'd0);
        r.x   = (($countones(a) % 2) == 1);
        r.e   = (a == c);
        r.n   = (a != c);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Model: an accepted op becomes visible LATENCY+2 edges later and stays
    // until out_ready is seen while visible.
    int    edge_n = 0;
    int    m_due;
    logic  m_busy, m_vis;
    res8_t m_pend, m_out;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_vis  <= 1'b0;
            m_out  <= '0;
            m_pend <= '0;
            m_due  <= 0;
        end else begin
            edge_n <= edge_n + 1;
            if (!m_busy) begin
                if (in_valid) begin
                    m_busy <= 1'b1;
                    m_due  <= edge_n + int'(L) + 2;
                    m_pend <= ref8(in_i1, in_i2, in_i3);
                end
            end else if (!m_vis) begin
                if (edge_n == m_due) begin
                    m_vis <= 1'b1;
                    m_out <= m_pend;
                end
            end else if (out_ready) begin
                m_vis  <= 1'b0;
                m_busy <= 1'b0;
            end
        end
    end

    // Per-cycle compare of the whole output bundle.
    always @(negedge clk) begin
        if (rst_n) begin
            vectors++;
            if ({out_valid, in_ready, busy, out_sum, out_sub, out_and, out_or, out_xor, out_eq, out_neq}
                !== {m_vis, !m_busy, m_busy, m_out}) begin
                miscompares++;
                $display("FAIL cycle t=%0t: got v=%b rdy=%b busy=%b res=%h expected v=%b rdy=%b busy=%b res=%h",
                         $time, out_valid, in_ready, busy,
                         {out_sum, out_sub, out_and, out_or, out_xor, out_eq, out_neq},
                         m_vis, !m_busy, m_busy, m_out);
            end
        end
    end

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, output int lat);
        int n;
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        in_valid  = 1'b1;
        in_i1     = a;
        in_i2     = b;
        in_i3     = c;
        out_ready = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            #1;
        end while (!out_valid && lat < 50);
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk("release_out_valid", 32'(out_valid), 0);
        chk("release_in_ready", 32'(in_ready), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int lat;
        in_valid = 1'b0; out_ready = 1'b0;
        in_i1 = '0; in_i2 = '0; in_i3 = '0;
        d0_in_valid = 1'b0; d0_out_ready = 1'b0;
        d0_in_i1 = '0; d0_in_i2 = '0; d0_in_i3 = '0;

        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        chk("reset_in_ready", 32'(in_ready), 1);
        chk("reset_out_valid", 32'(out_valid), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_d0_in_ready", 32'(d0_in_ready), 1);

        // All-ones + 1 wraps to zero; latency LATENCY+2.
        run_op(8'hFF, 8'h01, 8'hFF, lat);
        chk("lat_l4", 32'(lat), 6);
        chk("ff01_sum", 32'(out_sum), 32'h00);
        chk("ff01_sub", 32'(out_sub), 32'hFE);
        chk("ff01_flags", 32'({out_and, out_or, out_xor, out_eq, out_neq}), 32'b11010);
        release_out();

        // Carry through every bit position.
        run_op(8'h55, 8'hAB, 8'h54, lat);
        chk("55ab_sum", 32'(out_sum), 32'h00);
        chk("55ab_sub", 32'(out_sub), 32'hAA);
        chk("55ab_flags", 32'({out_and, out_or, out_xor, out_eq, out_neq}), 32'b01001);
        release_out();

        // No stale carry after a wrapping op.
        run_op(8'hFF, 8'h01, 8'h00, lat);
        release_out();
        run_op(8'h00, 8'h00, 8'h00, lat);
        chk("hist_sum", 32'(out_sum), 32'h00);
        chk("hist_sub", 32'(out_sub), 32'h00);
        chk("hist_eq", 32'(out_eq), 1);
        release_out();

        // Back-pressure for 10 cycles.
        run_op(8'h12, 8'h34, 8'h12, lat);
        repeat (10) @(negedge clk);
        chk("bp_sum", 32'(out_sum), 32'h46);
        chk("bp_sub", 32'(out_sub), 32'hDE);
        chk("bp_valid", 32'(out_valid), 1);
        chk("bp_in_ready", 32'(in_ready), 0);
        chk("bp_busy", 32'(busy), 1);
        release_out();

        // Reset two cycles after accept aborts the op.
        @(negedge clk);
        in_valid = 1'b1; in_i1 = 8'h0F; in_i2 = 8'h0F; in_i3 = 8'h0F;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 32'(out_valid), 0);
        chk("abort_in_ready", 32'(in_ready), 1);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_sum", 32'(out_sum), 0);
        chk("abort_sub", 32'(out_sub), 0);
        chk("abort_flags", 32'({out_and, out_or, out_xor, out_eq, out_neq}), 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("abort_no_result", 32'(out_valid), 0);
        end

        // LATENCY=0 instance.
        @(negedge clk);
        d0_in_valid = 1'b1; d0_in_i1 = 5'h1F; d0_in_i2 = 5'h01; d0_in_i3 = 5'h1E;
        @(posedge clk);
        #1 d0_in_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            #1;
        end while (!d0_out_valid && lat < 50);
        chk("lat_l0", 32'(lat), 2);
        chk("l0_sum", 32'(d0_out_sum), 32'h00);
        chk("l0_sub", 32'(d0_out_sub), 32'h1E);
        chk("l0_flags", 32'({d0_out_and, d0_out_or, d0_out_xor, d0_out_eq, d0_out_neq}), 32'b11101);
        @(negedge clk);
        d0_out_ready = 1'b1;
        @(posedge clk);
        #1 d0_out_ready = 1'b0;
        chk("l0_release_valid", 32'(d0_out_valid), 0);
        chk("l0_release_in_ready", 32'(d0_in_ready), 1);

        // Random traffic, including in_valid while busy.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            in_valid  = 1'($urandom_range(0, 1));
            in_i1     = 8'($urandom);
            in_i2     = 8'($urandom);
            in_i3     = ($urandom_range(0, 3) == 0) ? in_i1 : 8'($urandom);
            out_ready = ($urandom_range(0, 3) == 0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (20) @(negedge clk);
        chk("drain_idle", 32'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
